// File: rtl/ast_mx_pkg.sv
// rtl/ast_mx_pkg.sv - shared types and default sizes for the stream multiplexer
package ast_mx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH    = 64;
    localparam int DEF_CHANNEL_WIDTH = 8;
    localparam int DEF_RX_DIR        = 4;

endpackage

// File: rtl/ast_mx_rr_arbiter.sv
// rtl/ast_mx_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    logic [W-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last_grant) + i) % N);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ast_mx.sv
// rtl/ast_mx.sv - packet-atomic round-robin stream multiplexer with one output register stage
module ast_mx
    import ast_mx_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int RX_DIR        = DEF_RX_DIR,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1 ? 1 : $clog2(RX_DIR))
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR],
    input  logic [RX_DIR-1:0]        ast_startofpacket_i,
    input  logic [RX_DIR-1:0]        ast_endofpacket_i,
    input  logic [RX_DIR-1:0]        ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR],
    output logic [RX_DIR-1:0]        ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0] src_o,
    input  logic                     ast_ready_i
);

    state_t                   state;
    logic [DIR_SEL_WIDTH-1:0] last_grant;
    logic [DIR_SEL_WIDTH-1:0] owner;
    logic [DIR_SEL_WIDTH-1:0] arb_grant;
    logic                     arb_valid;
    logic [DIR_SEL_WIDTH-1:0] cur;
    logic                     cur_active;
    logic                     stage_free;
    logic                     xfer;

    rr_arbiter #(
        .N (RX_DIR),
        .W (DIR_SEL_WIDTH)
    ) u_arb (
        .req         (ast_valid_i),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // A locked packet keeps its source even through valid gaps on that source.
    always_comb begin
        cur        = (state == LOCKED) ? owner : arb_grant;
        cur_active = (state == LOCKED) || arb_valid;
        stage_free = !ast_valid_o || ast_ready_i;
    end

    always_comb begin
        ast_ready_o = '0;
        if (!srst_i && stage_free && cur_active)
            ast_ready_o[cur] = 1'b1;
    end

    assign xfer = ast_valid_i[cur] && ast_ready_o[cur];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            last_grant          <= DIR_SEL_WIDTH'(RX_DIR - 1);
            owner               <= '0;
            ast_valid_o         <= 1'b0;
            ast_startofpacket_o <= 1'b0;
            ast_endofpacket_o   <= 1'b0;
            ast_data_o          <= '0;
            ast_empty_o         <= '0;
            ast_channel_o       <= '0;
            src_o               <= '0;
        end else begin
            if (stage_free) begin
                ast_valid_o <= xfer;
                if (xfer) begin
                    ast_data_o          <= ast_data_i[cur];
                    ast_startofpacket_o <= ast_startofpacket_i[cur];
                    ast_endofpacket_o   <= ast_endofpacket_i[cur];
                    ast_empty_o         <= ast_empty_i[cur];
                    ast_channel_o       <= ast_channel_i[cur];
                    src_o               <= cur;
                end
            end
            // sop is not examined: only eop decides whether the lock is held or released.
            if (xfer) begin
                if (ast_endofpacket_i[cur]) begin
                    state      <= IDLE;
                    last_grant <= cur;
                end else begin
                    state <= LOCKED;
                    owner <= cur;
                end
            end
        end
    end

endmodule

// File: doc/ast_mx.md
AST_MX -- requirements
Module: ast_mx

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data bus width in bits.
REQ-002 Parameter CHANNEL_WIDTH, default 8, SHALL set the channel field width.
REQ-003 Parameter EMPTY_WIDTH, default $clog2(DATA_WIDTH/8), SHALL set the empty field width.
REQ-004 Parameter RX_DIR, default 4, SHALL set the number of input streams.
REQ-005 Parameter DIR_SEL_WIDTH, default (RX_DIR == 1 ? 1 : $clog2(RX_DIR)), SHALL set the source-index width.
REQ-006 Port order SHALL be clock and reset first: clk_i in 1, rising-edge clock; srst_i in 1, synchronous active-high reset.
REQ-007 ast_data_i in [RX_DIR][DATA_WIDTH]: input beat data, one slot per source.
REQ-008 ast_startofpacket_i in [RX_DIR]: input first beat; ast_endofpacket_i in [RX_DIR]: input last beat.
REQ-009 ast_valid_i in [RX_DIR]: input beat valid; ast_empty_i in [RX_DIR][EMPTY_WIDTH]: unused bytes in the last beat; ast_channel_i in [RX_DIR][CHANNEL_WIDTH]: channel tag.
REQ-010 ast_ready_o out [RX_DIR]: per-source ready.
REQ-011 Outputs: ast_data_o [DATA_WIDTH], ast_startofpacket_o 1, ast_endofpacket_o 1, ast_valid_o 1, ast_empty_o [EMPTY_WIDTH], ast_channel_o [CHANNEL_WIDTH], src_o [DIR_SEL_WIDTH] (source index of the current beat).
REQ-012 ast_ready_i in 1: downstream ready.

Function
REQ-013 A beat SHALL transfer on any port when valid and ready are both high at a rising clk_i edge.
REQ-014 FSM states SHALL be IDLE (no packet owned) and LOCKED (one source owns the output until its eop beat transfers).
REQ-015 In IDLE, the round-robin arbiter SHALL grant the first source with ast_valid_i high, searching from (last_grant+1) mod RX_DIR upward with wrap-around. last_grant resets to RX_DIR-1, so source 0 has first priority.
REQ-016 The granted source's first beat SHALL be accepted in the same cycle as the grant (zero arbitration bubble), subject to REQ-018.
REQ-017 An accepted beat with eop=0 SHALL move the FSM IDLE->LOCKED. An accepted eop beat SHALL move the FSM to IDLE and update last_grant, so back-to-back packets from different sources carry no idle cycle.
REQ-018 Output SHALL be one register stage: stage_free = !ast_valid_o || ast_ready_i; ast_ready_o[k] = stage_free && (k == grant); every other ast_ready_o bit = 0.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to ast_valid_o with that beat; data, sop, eop, empty and channel SHALL pass through unmodified, and src_o SHALL equal the granted index.
REQ-020 Output fields SHALL stay stable while ast_valid_o=1 and ast_ready_i=0.
REQ-021 In LOCKED, valid from non-granted sources SHALL be ignored, and a gap in the granted source's valid SHALL keep the lock.
REQ-022 A single-beat packet (sop=eop=1) SHALL keep the FSM in IDLE and still advance last_grant.
REQ-023 sop is not checked: the first beat granted in IDLE SHALL be treated as the packet start. A sop seen while LOCKED SHALL be forwarded without effect on the FSM.
REQ-024 Full throughput of 1 beat/cycle SHALL be sustained while ast_ready_i=1.

Reset
REQ-025 While srst_i=1: FSM=IDLE, last_grant=RX_DIR-1, ast_valid_o=0, ast_startofpacket_o=0, ast_endofpacket_o=0, ast_data_o=0, ast_empty_o=0, ast_channel_o=0, src_o=0, all ast_ready_o=0.
REQ-026 Reset asserted mid-packet SHALL drop the packet and any registered output beat with no partial eop generated; the first cycle after reset SHALL behave as a fresh IDLE.

Structure
REQ-027 Package ast_mx_pkg SHALL hold the state enum (IDLE, LOCKED) and the default parameter constants.
REQ-028 Round-robin grant logic SHALL be the sub-module rr_arbiter (inputs: request vector, last_grant; outputs: grant index, grant_valid), purely combinational.

Verification
REQ-029 The bench SHALL cover: valid only on source 2, 3-beat packet, ast_ready_i=1 -> src_o=2 beats on cycles 1..3, sop on beat 1, eop on beat 3, all ast_ready_o bits other than [2] stay 0.
REQ-030 The bench SHALL cover: all 4 sources continuously offering 2-beat packets -> grant order 0,1,2,3,0 with no idle cycle between packets.
REQ-031 The bench SHALL cover: source 1 mid-packet drops valid for 3 cycles while source 0 is valid -> output stays with src_o=1 until source 1's eop; source 0 is granted next.
REQ-032 The bench SHALL cover: ast_ready_i toggled 0/1 every cycle during a 5-beat packet -> the 5 beats emerge in order, unduplicated, with fields stable while stalled.
REQ-033 The bench SHALL cover: single-beat packets (sop=eop=1) on sources 0 and 3 simultaneously -> output 0 then 3 on consecutive cycles.
REQ-034 The bench SHALL cover: srst_i pulsed for 1 cycle after beat 2 of a 4-beat packet -> ast_valid_o=0 the next cycle, and a new packet from source 0 is granted first.
